// File: rtl/rr_mux8to1.sv
// 8-to-1 valid/ready collector with a single registered output slot.
// Round-robin arbitration by default; define RR_MUX_PRIORITY_EN for fixed lowest-index priority.
module rr_mux8to1 #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [7:0]      in_valid,
  input  logic [8*DW-1:0] in_data,
  output logic [7:0]      in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic [2:0]      out_sel,
  input  logic            out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e              state_q;
  logic [DW-1:0]       out_data_q;
  logic [2:0]          out_sel_q;
  logic [7:0][DW-1:0]  ch_data;
  logic                load_ok;
  logic                gnt_vld;
  logic [2:0]          gnt_idx;
  logic                grant;

  assign ch_data = in_data;

`ifdef RR_MUX_PRIORITY_EN
  // Descending scan so the lowest requesting index is the last assignment.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (in_valid[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = 3'(i);
      end
    end
  end
`else
  logic [2:0] ptr_q;

  // Scan ptr+1 .. ptr+8 (mod 8); descending offsets let the nearest requester win.
  always_comb begin
    logic [2:0] idx;
    gnt_vld = 1'b0;
    gnt_idx = 3'd0;
    idx     = 3'd0;
    for (int k = 8; k >= 1; k--) begin
      idx = ptr_q + 3'(k);
      if (in_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        ptr_q <= 3'd7;
    else if (grant) ptr_q <= gnt_idx;
  end
`endif

  assign load_ok  = (state_q == EMPTY) | out_ready;
  assign grant    = load_ok & gnt_vld & ~rst;
  assign in_ready = grant ? (8'd1 << gnt_idx) : 8'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      out_data_q <= '0;
      out_sel_q  <= 3'd0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (grant) begin
            state_q    <= FULL;
            out_data_q <= ch_data[gnt_idx];
            out_sel_q  <= gnt_idx;
          end
        end
        FULL: begin
          // A consume with a simultaneous grant refills the slot without a bubble.
          if (grant) begin
            out_data_q <= ch_data[gnt_idx];
            out_sel_q  <= gnt_idx;
          end else if (out_ready) begin
            state_q    <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign out_valid = (state_q == FULL);
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_rr_mux8to1.sv
// Scoreboard bench for rr_mux8to1: stimulus pushes expected words, negedge monitor pops and compares.
module tb_rr_mux8to1;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [7:0]      in_valid = '0;
  logic [8*DW-1:0] in_data = '0;
  logic [7:0]      in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_sel;
  logic            out_ready = 1'b0;

  rr_mux8to1 #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_sel(out_sel), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic [2:0] s; } item_t;
  item_t sb[$];

  int n_pass = 0;
  int n_total = 0;
  int m_ptr = 7;
  bit exp_valid = 1'b0;
  bit mon_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s got=%0h expected=%0h t=%0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  // Reference: grant the first requester in arbitration order when the slot can accept.
  task automatic cycle(input logic [7:0] iv, input logic [8*DW-1:0] id, input bit ordy,
                       output int g);
    bit held, lok;
    logic [7:0] er;
    @(posedge clk);
    #1;
    in_valid = iv; in_data = id; out_ready = ordy;
    #1;
    held = (sb.size() > 0);
    lok  = !held || ordy;
    g = -1;
    if (lok) begin
      for (int k = 1; k <= 8; k++) begin
`ifdef RR_MUX_PRIORITY_EN
        int c = k - 1;
`else
        int c = (m_ptr + k) % 8;
`endif
        if (g < 0 && iv[c]) g = c;
      end
    end
    er = (g >= 0) ? (8'd1 << g) : 8'd0;
    chk("in_ready", in_ready, er);
    exp_valid = held;
    if (g >= 0) begin
      item_t it;
      it.d = id[g*DW +: DW];
      it.s = 3'(g);
      sb.push_back(it);
`ifndef RR_MUX_PRIORITY_EN
      m_ptr = g;
`endif
    end
  endtask

  task automatic finish_reset();
    in_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    m_ptr = 7;
    exp_valid = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic rst_seq();
    mon_en = 1'b0;
    rst = 1'b1;
    in_valid = 8'hFF;
    out_ready = 1'b1;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_in_ready", in_ready, 0);
    finish_reset();
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("out_valid", out_valid, exp_valid);
      if (out_valid) begin
        if (sb.size() == 0) chk("sb_nonempty", 0, 1);
        else begin
          chk("out_data", out_data, sb[0].d);
          chk("out_sel", out_sel, sb[0].s);
          if (out_ready) void'(sb.pop_front());
        end
      end
    end
  end

  function automatic logic [8*DW-1:0] rnd_data();
    return {$urandom, $urandom};
  endfunction

  initial begin
    int g;
    logic [8*DW-1:0] d;

    // Single-channel grant right after reset, 1-cycle latency.
    #12;
    rst_seq();
    d = rnd_data();
    d[7:0] = 8'hA5;
    cycle(8'h01, d, 1'b1, g);
    chk("first_grant", in_ready, 8'h01);
    cycle(8'h00, rnd_data(), 1'b1, g);
    chk("first_valid", out_valid, 1);
    chk("first_data", out_data, 8'hA5);
    chk("first_sel", out_sel, 0);

    // All channels requesting, sink always ready.
    rst_seq();
    for (int i = 0; i < 9; i++) begin
      cycle(8'hFF, rnd_data(), 1'b1, g);
`ifdef RR_MUX_PRIORITY_EN
      chk("pri_seq", in_ready, 8'h01);
`else
      chk("rr_seq", in_ready, 8'd1 << (i % 8));
`endif
    end

    // Stall with channel 3 held, upper channels waiting.
    rst_seq();
    cycle(8'h08, rnd_data(), 1'b1, g);
    for (int i = 0; i < 4; i++) begin
      cycle(8'hF0, rnd_data(), 1'b0, g);
      chk("stall_ready", in_ready, 0);
      chk("stall_sel", out_sel, 3);
    end
    cycle(8'hF0, rnd_data(), 1'b1, g);
    chk("unstall_grant", in_ready, 8'h10);

    // Pointer wrap from channel 6.
    rst_seq();
    cycle(8'h40, rnd_data(), 1'b1, g);
    cycle(8'h05, rnd_data(), 1'b1, g);
    chk("wrap_first", in_ready, 8'h01);
    cycle(8'h05, rnd_data(), 1'b1, g);
`ifdef RR_MUX_PRIORITY_EN
    chk("wrap_second", in_ready, 8'h01);
`else
    chk("wrap_second", in_ready, 8'h04);
`endif

    // Reset while a word is held: it must vanish and never reappear.
    rst_seq();
    d = rnd_data();
    d[7:0] = 8'h3C;
    cycle(8'h01, d, 1'b1, g);
    cycle(8'h00, rnd_data(), 1'b0, g);
    chk("held_3c", out_data, 8'h3C);
    #1;
    mon_en = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    finish_reset();
    for (int i = 0; i < 3; i++) cycle(8'h00, rnd_data(), 1'b1, g);

    // Randomized traffic; channels may drop valid without being granted.
    rst_seq();
    for (int i = 0; i < 400; i++) begin
      logic [7:0] iv;
      iv = 8'($urandom) & 8'($urandom | $urandom);
      cycle(iv, rnd_data(), ($urandom_range(0, 3) != 0), g);
    end
    for (int i = 0; i < 2; i++) cycle(8'h00, rnd_data(), 1'b1, g);
    @(posedge clk);
    #1;
    chk("sb_drained", sb.size(), 0);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
